// File: rtl/selector_2bits_rr_feeder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | selector_2bits_rr_feeder_if : producer/selector/consumer bus of the feeder  |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
interface selector_2bits_rr_feeder_if #(
  parameter int DATA_WIDTH = 8
);
  logic [3:0]            in_valid;
  logic [DATA_WIDTH-1:0] in_data1;
  logic [DATA_WIDTH-1:0] in_data2;
  logic [DATA_WIDTH-1:0] in_data3;
  logic [DATA_WIDTH-1:0] in_data4;
  logic [3:0]            in_ready;
  logic [DATA_WIDTH-1:0] number1;
  logic [DATA_WIDTH-1:0] number2;
  logic [DATA_WIDTH-1:0] number3;
  logic [DATA_WIDTH-1:0] number4;
  logic [1:0]            select;
  logic                  out_valid;
  logic                  out_ready;

  // Environment side: producers and the consumer.
  modport master (
    output in_valid, in_data1, in_data2, in_data3, in_data4, out_ready,
    input  in_ready, number1, number2, number3, number4, select, out_valid
  );

  // Feeder side.
  modport slave (
    input  in_valid, in_data1, in_data2, in_data3, in_data4, out_ready,
    output in_ready, number1, number2, number3, number4, select, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/selector_2bits_rr_feeder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | selector_2bits_rr_feeder : four one-byte holding registers, round-robin     |
// | arbitration and valid/ready qualification for the 4:1 byte selector.        |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module selector_2bits_rr_feeder #(
  parameter int DATA_WIDTH = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  selector_2bits_rr_feeder_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [3:0]                  full_q, full_d;
  logic [3:0][DATA_WIDTH-1:0]  num_q, num_d;
  logic [1:0]                  select_q, select_d;
  logic [1:0]                  rr_ptr_q, rr_ptr_d;
  logic                        out_valid_q, out_valid_d;

  logic [3:0][DATA_WIDTH-1:0]  in_data;
  logic [3:0]                  wr_en;
  logic [3:0]                  sel_onehot;
  logic [3:0]                  remaining;
  logic                        accept;

  // First set bit of cand scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  // Scanning backwards lets the earliest hit overwrite later ones.
  function automatic logic [1:0] rr_pick(input logic [3:0] cand, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (cand[idx]) rr_pick = idx;
    end
  endfunction

  assign in_data    = {bus.in_data4, bus.in_data3, bus.in_data2, bus.in_data1};
  assign wr_en      = bus.in_valid & ~full_q;
  assign accept     = out_valid_q & bus.out_ready;
  assign sel_onehot = 4'b0001 << select_q;
  // Writes landing this cycle are deliberately not candidates yet.
  assign remaining  = full_q & ~sel_onehot;

  always_comb begin
    full_d = (full_q & ~(accept ? sel_onehot : 4'b0000)) | wr_en;
    num_d  = num_q;
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i]) num_d[i] = in_data[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    select_d    = select_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (|full_q) begin
          select_d    = rr_pick(full_q, rr_ptr_q);
          out_valid_d = 1'b1;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          rr_ptr_d = select_q + 2'd1;
          if (|remaining) begin
            select_d = rr_pick(remaining, select_q + 2'd1);
          end else begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      full_q      <= 4'b0000;
      num_q       <= '0;
      select_q    <= 2'b00;
      rr_ptr_q    <= 2'b00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      num_q       <= num_d;
      select_q    <= select_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = ~full_q;
  assign bus.number1   = num_q[0];
  assign bus.number2   = num_q[1];
  assign bus.number3   = num_q[2];
  assign bus.number4   = num_q[3];
  assign bus.select    = select_q;
  assign bus.out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_selector_2bits_rr_feeder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_selector_2bits_rr_feeder : directed self-checking bench for the feeder   |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_selector_2bits_rr_feeder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  selector_2bits_rr_feeder_if #(.DATA_WIDTH(8)) bus ();

  selector_2bits_rr_feeder #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte the selector would pass through for the current select.
  function automatic logic [7:0] result_byte();
    case (bus.select)
      2'd0:    return bus.number1;
      2'd1:    return bus.number2;
      2'd2:    return bus.number3;
      default: return bus.number4;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] sel, input logic [7:0] data);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'h1);
    chk({tag, "_select"}, 32'(bus.select), 32'(sel));
    chk({tag, "_byte"}, 32'(result_byte()), 32'(data));
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 4'hF;
    bus.in_data1  = 8'hFF;
    bus.in_data2  = 8'hFF;
    bus.in_data3  = 8'hFF;
    bus.in_data4  = 8'hFF;
    bus.out_ready = 1'b1;

    // Reset held with every producer offering: nothing may be captured.
    step(); step(); step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'hF);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_select", 32'(bus.select), 32'h0);
    chk("rst_numbers", {bus.number4, bus.number3, bus.number2, bus.number1}, 32'h0);
    bus.in_valid = 4'h0;
    rst_n        = 1'b1;
    step();
    chk("rst_rel_in_ready", 32'(bus.in_ready), 32'hF);

    // Load all four, stream back-to-back from rr_ptr=0.
    bus.in_valid = 4'hF;
    bus.in_data1 = 8'h11;
    bus.in_data2 = 8'h22;
    bus.in_data3 = 8'h33;
    bus.in_data4 = 8'h44;
    step();
    bus.in_valid = 4'h0;
    chk("all_loaded_in_ready", 32'(bus.in_ready), 32'h0);
    chk("all_loaded_not_valid", 32'(bus.out_valid), 32'h0);
    step();
    chk_grant("all_g0", 2'd0, 8'h11);
    step();
    chk_grant("all_g1", 2'd1, 8'h22);
    chk("all_g1_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    chk_grant("all_g2", 2'd2, 8'h33);
    step();
    chk_grant("all_g3", 2'd3, 8'h44);
    step();
    chk("all_done_valid", 32'(bus.out_valid), 32'h0);
    chk("all_done_in_ready", 32'(bus.in_ready), 32'hF);

    // Single byte on channel 3.
    bus.in_valid = 4'b0100;
    bus.in_data3 = 8'hA5;
    step();
    bus.in_valid = 4'h0;
    chk("ch3_in_ready", 32'(bus.in_ready), 32'hB);
    chk("ch3_latency", 32'(bus.out_valid), 32'h0);
    step();
    chk_grant("ch3_g", 2'd2, 8'hA5);
    step();
    chk("ch3_done_valid", 32'(bus.out_valid), 32'h0);
    chk("ch3_done_in_ready", 32'(bus.in_ready), 32'hF);

    // rr_ptr is now 3: with ch1 and ch4 full, ch4 wins then wraps to ch1.
    bus.in_valid = 4'b1001;
    bus.in_data1 = 8'hC1;
    bus.in_data4 = 8'hD4;
    step();
    bus.in_valid = 4'h0;
    step();
    chk_grant("wrap_g0", 2'd3, 8'hD4);
    step();
    chk_grant("wrap_g1", 2'd0, 8'hC1);
    step();
    chk("wrap_done_valid", 32'(bus.out_valid), 32'h0);

    // Stall with ch2 granted while ch1 refills behind it.
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0010;
    bus.in_data2  = 8'hB2;
    step();
    bus.in_valid = 4'h0;
    step();
    chk_grant("stall_g", 2'd1, 8'hB2);
    bus.in_valid = 4'b0001;
    bus.in_data1 = 8'hE1;
    step();
    bus.in_valid = 4'h0;
    bus.in_data2 = 8'h00;
    chk("stall_refill_in_ready", 32'(bus.in_ready), 32'hC);
    for (int c = 0; c < 4; c++) begin
      chk_grant($sformatf("stall_hold%0d", c), 2'd1, 8'hB2);
      chk($sformatf("stall_num2_%0d", c), 32'(bus.number2), 32'hB2);
      step();
    end
    chk_grant("stall_hold4", 2'd1, 8'hB2);
    bus.out_ready = 1'b1;
    step();
    chk_grant("stall_next", 2'd0, 8'hE1);
    step();
    chk("stall_done_valid", 32'(bus.out_valid), 32'h0);
    chk("stall_done_in_ready", 32'(bus.in_ready), 32'hF);

    // Asynchronous reset in the middle of a grant with three channels full.
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0111;
    bus.in_data1  = 8'h01;
    bus.in_data2  = 8'h02;
    bus.in_data3  = 8'h03;
    step();
    bus.in_valid = 4'h0;
    step();
    chk_grant("mid_g", 2'd1, 8'h02);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'hF);
    chk("mid_rst_select", 32'(bus.select), 32'h0);
    chk("mid_rst_numbers", {bus.number4, bus.number3, bus.number2, bus.number1}, 32'h0);
    step();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 4'b1000;
    bus.in_data4 = 8'h5A;
    step();
    bus.in_valid = 4'h0;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'h7);
    step();
    chk_grant("post_rst_g", 2'd3, 8'h5A);
    step();
    chk("post_rst_done_valid", 32'(bus.out_valid), 32'h0);
    chk("post_rst_done_in_ready", 32'(bus.in_ready), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
